johnson_updown_counter: RTL and testbench

JOHNSON_UPDOWN_COUNTER -- requirements
Module: johnson_updown_counter

---
 rtl/johnson_updown_counter.sv | 109 ++++++++++
 tb/tb_johnson_updown_counter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/johnson_updown_counter.sv
// Up/down Johnson counter with a registered binary index, load and self-check.
// Ports: clock, reset_n (async low), en, up, load, load_val[BW] -> q[N], br[BW], tc, err.
module johnson_updown_counter #(
  parameter  int N  = 6,
  localparam int BW = $clog2(2*N)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          en,
  input  logic          up,
  input  logic          load,
  input  logic [BW-1:0] load_val,
  output logic [N-1:0]  q,
  output logic [BW-1:0] br,
  output logic          tc,
  output logic          err
);

  localparam logic [BW-1:0] LAST = BW'(2*N-1);

  // Johnson pattern for index k: ones fill from bit 0 up
  // to k=N, then drain from bit 0 upward.
  function automatic logic [N-1:0] code(
    input logic [BW-1:0] k
  );
    logic [N-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(k) <= N)
        c[i] = (i < int'(k));
      else
        c[i] = (i >= int'(k) - N);
    end
    return c;
  endfunction

  logic [N-1:0]  q_r, q_nx;
  logic [BW-1:0] br_r, br_nx;
  logic          err_r, err_nx;

  logic bad_idx, fault, lv_ok;
  logic sel_ld, sel_bad, sel_up, sel_dn;

  // q must match the pattern implied by br; an index
  // outside 0..2N-1 or any non-Johnson q fails this too.
  assign bad_idx = int'(br_r) > 2*N-1;
  assign fault   = bad_idx | (q_r != code(br_r));
  assign lv_ok   = int'(load_val) < 2*N;

  assign sel_ld  = ~fault & load & lv_ok;
  assign sel_bad = ~fault & load & ~lv_ok;
  assign sel_up  = ~fault & ~load & en & up;
  assign sel_dn  = ~fault & ~load & en & ~up;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q_r   <= '0;
      br_r  <= '0;
      err_r <= 1'b0;
    end else begin
      q_r   <= q_nx;
      br_r  <= br_nx;
      err_r <= err_nx;
    end
  end

  always_comb begin
    q_nx   = q_r;
    br_nx  = br_r;
    err_nx = err_r;
    unique case (1'b1)
      fault: begin
        q_nx   = '0;
        br_nx  = '0;
        err_nx = 1'b1;
      end
      sel_ld: begin
        q_nx   = code(load_val);
        br_nx  = load_val;
        err_nx = 1'b0;
      end
      sel_bad: begin
        err_nx = 1'b1;
      end
      sel_up: begin
        q_nx  = {q_r[N-2:0], ~q_r[N-1]};
        br_nx = (br_r == LAST) ? '0 : br_r + 1'b1;
      end
      sel_dn: begin
        q_nx  = {~q_r[0], q_r[N-1:1]};
        br_nx = (br_r == '0) ? LAST : br_r - 1'b1;
      end
      default: begin
        q_nx   = q_r;
        br_nx  = br_r;
        err_nx = err_r;
      end
    endcase
  end

  assign q   = q_r;
  assign br  = br_r;
  assign err = err_r;

  assign tc = en & ~load &
              ((up & (br_r == LAST)) |
               (~up & (br_r == '0)));

endmodule

// File: tb/tb_johnson_updown_counter.sv
// Directed bench for johnson_updown_counter at N=6, N=2 and N=8.
// Table vectors on N=6 plus hand sequences for fault, reset and sweeps.
module tb_johnson_updown_counter;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       en, up, load;
  logic [3:0] lv6;

  logic [5:0] q6;
  logic [3:0] br6;
  logic       tc6, err6;
  logic [1:0] q2, br2;
  logic       tc2, err2;
  logic [7:0] q8;
  logic [3:0] br8;
  logic       tc8, err8;

  int checks   = 0;
  int failures = 0;
  int k2 = 0, k6 = 0, k8 = 0;

  always #5 clock = ~clock;

  johnson_updown_counter #(.N(6)) dut6 (
    .clock(clock), .reset_n(reset_n),
    .en(en), .up(up), .load(load),
    .load_val(lv6),
    .q(q6), .br(br6), .tc(tc6), .err(err6)
  );

  johnson_updown_counter #(.N(2)) dut2 (
    .clock(clock), .reset_n(reset_n),
    .en(en), .up(up), .load(1'b0),
    .load_val(2'b00),
    .q(q2), .br(br2), .tc(tc2), .err(err2)
  );

  johnson_updown_counter #(.N(8)) dut8 (
    .clock(clock), .reset_n(reset_n),
    .en(en), .up(up), .load(1'b0),
    .load_val(4'b0000),
    .q(q8), .br(br8), .tc(tc8), .err(err8)
  );

  typedef struct {
    logic       en;
    logic       up;
    logic       ld;
    logic [3:0] lv;
    logic       tc;
    logic [5:0] q;
    logic [3:0] br;
    logic       err;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    input logic e, u, l,
    input logic [3:0] v,
    input logic t,
    input logic [5:0] eq,
    input logic [3:0] eb,
    input logic ee
  );
    vec_t r;
    r.en = e; r.up = u; r.ld = l; r.lv = v;
    r.tc = t; r.q = eq; r.br = eb; r.err = ee;
    return r;
  endfunction

  function automatic logic [31:0] tbcode(
    input int n, input int k
  );
    logic [63:0] m;
    if (k <= n)
      m = (64'd1 << k) - 64'd1;
    else
      m = ((64'd1 << n) - 64'd1) &
          ~((64'd1 << (k - n)) - 64'd1);
    return m[31:0];
  endfunction

  function automatic logic tcexp(
    input int n, input int k
  );
    return en && !load &&
      ((up && k == 2*n-1) || (!up && k == 0));
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset_n) begin
      k2 = 0; k6 = 0; k8 = 0;
    end else if (en) begin
      k2 = up ? (k2 + 1) % 4  : (k2 + 3) % 4;
      k8 = up ? (k8 + 1) % 16 : (k8 + 15) % 16;
      if (!load)
        k6 = up ? (k6 + 1) % 12 : (k6 + 11) % 12;
    end
    #1;
  endtask

  task automatic chk_models(input bit with6);
    chk("n2_br", 32'(br2), 32'(k2));
    chk("n2_q", 32'(q2), tbcode(2, k2));
    chk("n2_err", 32'(err2), 32'd0);
    chk("n8_br", 32'(br8), 32'(k8));
    chk("n8_q", 32'(q8), tbcode(8, k8));
    chk("n8_err", 32'(err8), 32'd0);
    if (with6) begin
      chk("n6_br", 32'(br6), 32'(k6));
      chk("n6_q", 32'(q6), tbcode(6, k6));
    end
  endtask

  task automatic chk_tc_models();
    chk("n2_tc", 32'(tc2), 32'(tcexp(2, k2)));
    chk("n8_tc", 32'(tc8), 32'(tcexp(8, k8)));
    chk("n6_tc", 32'(tc6), 32'(tcexp(6, k6)));
  endtask

  initial begin
    tv.push_back(mk(1,0,0, 0,1,6'b100000,11,0));
    tv.push_back(mk(1,1,0, 0,1,6'b000000, 0,0));
    tv.push_back(mk(1,1,0, 0,0,6'b000001, 1,0));
    tv.push_back(mk(1,1,0, 0,0,6'b000011, 2,0));
    tv.push_back(mk(1,1,0, 0,0,6'b000111, 3,0));
    tv.push_back(mk(1,1,0, 0,0,6'b001111, 4,0));
    tv.push_back(mk(1,1,0, 0,0,6'b011111, 5,0));
    tv.push_back(mk(1,1,0, 0,0,6'b111111, 6,0));
    tv.push_back(mk(1,1,0, 0,0,6'b111110, 7,0));
    tv.push_back(mk(1,1,0, 0,0,6'b111100, 8,0));
    tv.push_back(mk(1,1,0, 0,0,6'b111000, 9,0));
    tv.push_back(mk(1,1,0, 0,0,6'b110000,10,0));
    tv.push_back(mk(1,1,0, 0,0,6'b100000,11,0));
    tv.push_back(mk(1,1,0, 0,1,6'b000000, 0,0));
    tv.push_back(mk(0,1,0, 0,0,6'b000000, 0,0));
    tv.push_back(mk(0,0,0, 0,0,6'b000000, 0,0));
    tv.push_back(mk(1,0,0, 0,1,6'b100000,11,0));
    tv.push_back(mk(1,1,0, 0,1,6'b000000, 0,0));
    tv.push_back(mk(1,1,0, 0,0,6'b000001, 1,0));
    tv.push_back(mk(1,0,0, 0,0,6'b000000, 0,0));
    tv.push_back(mk(1,1,1, 7,0,6'b111110, 7,0));
    tv.push_back(mk(1,1,1,12,0,6'b111110, 7,1));
    tv.push_back(mk(1,1,0, 0,0,6'b111100, 8,1));
    tv.push_back(mk(0,0,1, 3,0,6'b000111, 3,0));
    tv.push_back(mk(1,1,1,11,0,6'b100000,11,0));
    tv.push_back(mk(1,1,0, 0,1,6'b000000, 0,0));
    tv.push_back(mk(1,0,1,15,0,6'b000000, 0,1));
    tv.push_back(mk(0,0,1, 0,0,6'b000000, 0,0));
    tv.push_back(mk(0,0,1, 6,0,6'b111111, 6,0));
    tv.push_back(mk(0,1,0, 0,0,6'b111111, 6,0));

    reset_n = 1'b0;
    en = 1'b0; up = 1'b0; load = 1'b0; lv6 = '0;
    #12;
    chk("rst_q", 32'(q6), 32'd0);
    chk("rst_br", 32'(br6), 32'd0);
    chk("rst_err", 32'(err6), 32'd0);
    chk("rst_tc", 32'(tc6), 32'd0);
    chk_models(1'b1);
    reset_n = 1'b1;
    tick();

    foreach (tv[i]) begin
      en = tv[i].en; up = tv[i].up;
      load = tv[i].ld; lv6 = tv[i].lv;
      #1;
      chk($sformatf("v%0d_tc", i),
          32'(tc6), 32'(tv[i].tc));
      tick();
      chk($sformatf("v%0d_q", i),
          32'(q6), 32'(tv[i].q));
      chk($sformatf("v%0d_br", i),
          32'(br6), 32'(tv[i].br));
      chk($sformatf("v%0d_err", i),
          32'(err6), 32'(tv[i].err));
      chk_models(1'b0);
    end

    // Corrupt q for one edge with en=1: must clear, not step.
    en = 1'b1; up = 1'b1; load = 1'b0; lv6 = '0;
    force dut6.q_r = 6'b010101;
    tick();
    release dut6.q_r;
    chk("flt_br", 32'(br6), 32'd0);
    chk("flt_err", 32'(err6), 32'd1);
    en = 1'b0;
    tick();
    chk("flt_q2", 32'(q6), 32'd0);
    chk("flt_br2", 32'(br6), 32'd0);
    chk("flt_err2", 32'(err6), 32'd1);
    chk_models(1'b0);

    // Async reset between edges at count 5 with err set.
    load = 1'b1; lv6 = 4'd5;
    tick();
    chk("ld5_q", 32'(q6), 32'b011111);
    chk("ld5_err", 32'(err6), 32'd0);
    lv6 = 4'd13;
    tick();
    chk("ld13_br", 32'(br6), 32'd5);
    chk("ld13_err", 32'(err6), 32'd1);
    load = 1'b0; en = 1'b1; up = 1'b0;
    #3;
    reset_n = 1'b0;
    k2 = 0; k6 = 0; k8 = 0;
    #1;
    chk("ar_q", 32'(q6), 32'd0);
    chk("ar_br", 32'(br6), 32'd0);
    chk("ar_err", 32'(err6), 32'd0);
    chk("ar_tc", 32'(tc6), 32'd1);
    chk_models(1'b1);
    tick();
    chk("ar_hold_br", 32'(br6), 32'd0);
    chk_models(1'b1);
    reset_n = 1'b1; up = 1'b1;
    tick();
    chk("rel_q", 32'(q6), 32'b000001);
    chk("rel_br", 32'(br6), 32'd1);
    chk_models(1'b1);

    // Full up then down sweeps on all widths.
    for (int d = 0; d < 2; d++) begin
      up = (d == 0);
      for (int s = 0; s < 20; s++) begin
        #1;
        chk_tc_models();
        tick();
        chk_models(1'b1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
